chien_forney_16_8: RTL and testbench

Error locator/evaluator for the RS(16,8) decoder over GF(256). It takes Λ(x) and Ω(x) from the key-equation solver and runs a Chien search over the 16 codeword positions, one position per cycle. For each root found it computes the error value with Forney's formula. It streams per-position error results and, on completion, a registered 128-bit correction vector for XOR with the buffered received word.

---
 rtl/chien_forney_16_8.sv | 174 +++++++++++++++++
 tb/tb_chien_forney_16_8.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/chien_forney_16_8.sv
// RS(16,8) Chien search with Forney error evaluation over GF(256), poly 0x11D.
// Scans one codeword position per cycle and emits per-root results plus a correction vector.
//
// state | meaning
// IDLE  | waiting for start; summary outputs hold their last values
// SCAN  | evaluating position pos_q (0..15), one per cycle
module chien_forney_16_8 #(
  parameter int SYM_BW = 8,
  parameter int N_NUM  = 16,
  parameter int T      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SYM_BW*(T+1)-1:0]   lamda,
  input  logic [SYM_BW*T-1:0]       omega,
  output logic                      busy,
  output logic                      err_valid,
  output logic [3:0]                err_pos,
  output logic [SYM_BW-1:0]         err_val,
  output logic                      done,
  output logic [4:0]                err_cnt,
  output logic                      fail,
  output logic [SYM_BW*N_NUM-1:0]   err_vec
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state_q, state_d;

  logic [T:0][SYM_BW-1:0]   lam_q, lam_nxt;
  logic [T-1:0][SYM_BW-1:0] om_q, om_nxt;
  logic [3:0]               pos_q;
  logic [2:0]               deg_q, deg_in;
  logic                     fail_flag_q;

  logic [SYM_BW-1:0]        lam_sum, odd_sum, om_sum, e_val;
  logic                     is_root, deriv_zero, last, fail_nxt, fail_final;
  logic [4:0]               cnt_nxt;
  logic [SYM_BW*N_NUM-1:0]  vec_nxt;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  // a^254 == a^-1 for nonzero a
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int k = 1; k < 8; k++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] mul_ainv(input logic [7:0] x);
    return {1'b0, x[7:1]} ^ (x[0] ? 8'h8E : 8'h00);
  endfunction

  assign busy = (state_q == SCAN);

  always_comb begin
    deg_in = '0;
    for (int i = 1; i <= T; i++) begin
      if (lamda[i*SYM_BW +: SYM_BW] != '0) deg_in = 3'(i);
    end
  end

  always_comb begin
    lam_sum = '0;
    odd_sum = '0;
    om_sum  = '0;
    lam_nxt = lam_q;
    om_nxt  = om_q;
    for (int i = 0; i <= T; i++) begin
      lam_sum = lam_sum ^ lam_q[i];
      if (i % 2 == 1) odd_sum = odd_sum ^ lam_q[i];
      for (int j = 0; j < i; j++) lam_nxt[i] = mul_ainv(lam_nxt[i]);
    end
    for (int i = 0; i < T; i++) begin
      om_sum = om_sum ^ om_q[i];
      for (int j = 0; j < i; j++) om_nxt[i] = mul_ainv(om_nxt[i]);
    end
  end

  // The formal derivative at a^-p equals a^p times the odd-term sum, so the
  // a^p factor of Forney's formula cancels and e = Omega / odd_sum.
  always_comb begin
    is_root    = (state_q == SCAN) && (lam_sum == '0);
    deriv_zero = (odd_sum == '0);
    e_val      = deriv_zero ? '0 : gf_mul(om_sum, gf_inv(odd_sum));
    cnt_nxt    = (is_root && err_cnt != 5'd31) ? err_cnt + 5'd1 : err_cnt;
    vec_nxt    = err_vec;
    if (is_root) vec_nxt[{pos_q, 3'b000} +: SYM_BW] = e_val;
    fail_nxt   = fail_flag_q | (is_root & deriv_zero);
    fail_final = fail_nxt | (cnt_nxt != {2'b00, deg_q});
    last       = (pos_q == 4'd15);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (!start && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lam_q       <= '0;
      om_q        <= '0;
      pos_q       <= '0;
      deg_q       <= '0;
      fail_flag_q <= 1'b0;
      err_valid   <= 1'b0;
      err_pos     <= '0;
      err_val     <= '0;
      done        <= 1'b0;
      err_cnt     <= '0;
      fail        <= 1'b0;
      err_vec     <= '0;
    end else begin
      err_valid <= 1'b0;
      done      <= 1'b0;
      if (start) begin
        lam_q       <= lamda;
        om_q        <= omega;
        pos_q       <= '0;
        deg_q       <= deg_in;
        fail_flag_q <= (lamda[SYM_BW-1:0] == '0);
        err_pos     <= '0;
        err_val     <= '0;
        err_cnt     <= '0;
        fail        <= 1'b0;
        err_vec     <= '0;
      end else if (state_q == SCAN) begin
        lam_q       <= lam_nxt;
        om_q        <= om_nxt;
        pos_q       <= pos_q + 4'd1;
        fail_flag_q <= fail_nxt;
        err_valid   <= is_root;
        if (is_root) begin
          err_pos <= pos_q;
          err_val <= e_val;
        end
        err_cnt <= cnt_nxt;
        err_vec <= vec_nxt;
        if (last) begin
          done <= 1'b1;
          fail <= fail_final;
          if (fail_final) err_vec <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_chien_forney_16_8.sv
// Directed bench for chien_forney_16_8: known error patterns, boundary Lambdas,
// restart during a scan and reset during a scan.
module tb_chien_forney_16_8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [39:0]   lamda = '0;
  logic [31:0]   omega = '0;
  logic          busy, err_valid, done, fail;
  logic [3:0]    err_pos;
  logic [7:0]    err_val;
  logic [4:0]    err_cnt;
  logic [127:0]  err_vec;

  chien_forney_16_8 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lamda(lamda), .omega(omega),
    .busy(busy), .err_valid(err_valid), .err_pos(err_pos), .err_val(err_val),
    .done(done), .err_cnt(err_cnt), .fail(fail), .err_vec(err_vec)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int           n_ev, n_done, done_at;
  logic [3:0]   ev_pos [8];
  logic [7:0]   ev_val [8];
  int           ev_cyc [8];
  logic [4:0]   cnt_d, cnt_hold;
  logic         fail_d, b1, b16, b17;
  logic [127:0] vec_d;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_apow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = m_mul(r, 8'h02);
    return r;
  endfunction

  // Omega = S(x)*Lambda(x) mod x^4 for errors 0x01 at p=0 and 0xAA at p=15
  function automatic logic [31:0] two_err_omega(input logic [39:0] l);
    logic [7:0]  s [4];
    logic [31:0] o;
    o = '0;
    for (int j = 0; j < 4; j++) s[j] = 8'h01 ^ m_mul(8'hAA, m_apow(15 * j));
    for (int i = 0; i < 4; i++)
      for (int k = 0; k <= i; k++)
        o[i*8 +: 8] = o[i*8 +: 8] ^ m_mul(s[k], l[(i-k)*8 +: 8]);
    return o;
  endfunction

  task automatic run(input logic [39:0] l, input logic [31:0] o, input int restart_at,
                     input logic [39:0] l2, input logic [31:0] o2, input int ncyc);
    int base;
    base = 0; n_ev = 0; n_done = 0; done_at = -1;
    b1 = 1'b0; b16 = 1'b0; b17 = 1'b1;
    cnt_d = 'x; fail_d = 1'bx; vec_d = 'x;
    @(negedge clk);
    lamda = l; omega = o; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (err_valid && n_ev < 8) begin
        ev_pos[n_ev] = err_pos; ev_val[n_ev] = err_val; ev_cyc[n_ev] = c - base;
        n_ev++;
      end
      if (done) begin
        n_done++; done_at = c - base;
        cnt_d = err_cnt; fail_d = fail; vec_d = err_vec;
      end
      if (c - base == 1)  b1  = busy;
      if (c - base == 16) b16 = busy;
      if (c - base == 17) b17 = busy;
      if (c == restart_at) begin
        lamda = l2; omega = o2; start = 1'b1;
        base = c; n_ev = 0; n_done = 0; done_at = -1;
      end
    end
    cnt_hold = err_cnt;
  endtask

  logic [31:0]  om2;
  logic [127:0] vec2;
  int           dn;

  initial begin
    vec2 = '0;
    vec2[7:0] = 8'h01;
    vec2[127:120] = 8'hAA;
    om2 = two_err_omega(40'h0000262701);

    repeat (2) @(negedge clk);
    check_val("reset_outs", {busy, err_valid, done, fail, err_cnt, err_pos, err_val}, '0);
    check_val("reset_vec", err_vec, '0);
    rst_n = 1'b1;

    // no error
    run(40'h0000000001, 32'h0, 0, '0, '0, 30);
    check_val("noerr_events", n_ev, 0);
    check_val("noerr_done_cnt", n_done, 1);
    check_val("noerr_done_at", done_at, 17);
    check_val("noerr_busy", {b1, b16, b17}, 3'b110);
    check_val("noerr_summary", {fail_d, cnt_d}, 6'd0);
    check_val("noerr_vec", vec_d, '0);

    // single error p=3 value 0x55
    run(40'h0000000801, 32'h00000055, 0, '0, '0, 30);
    check_val("single_events", n_ev, 1);
    check_val("single_ev", {ev_cyc[0][7:0], ev_pos[0], ev_val[0]}, {8'd5, 4'd3, 8'h55});
    check_val("single_summary", {n_done[1:0], done_at[7:0], fail_d, cnt_d}, {2'd1, 8'd17, 1'b0, 5'd1});
    check_val("single_vec", vec_d, 128'h55 << 24);
    check_val("single_hold", cnt_hold, 5'd1);

    // two errors at p=0 and p=15
    run(40'h0000262701, om2, 0, '0, '0, 30);
    check_val("two_events", n_ev, 2);
    check_val("two_ev0", {ev_cyc[0][7:0], ev_pos[0], ev_val[0]}, {8'd2, 4'd0, 8'h01});
    check_val("two_ev1", {ev_cyc[1][7:0], ev_pos[1], ev_val[1]}, {8'd17, 4'd15, 8'hAA});
    check_val("two_summary", {n_done[1:0], done_at[7:0], fail_d, cnt_d}, {2'd1, 8'd17, 1'b0, 5'd2});
    check_val("two_vec", vec_d, vec2);

    // root outside the 16 positions
    run(40'h000000B401, 32'h0, 0, '0, '0, 30);
    check_val("oor_events", n_ev, 0);
    check_val("oor_summary", {n_done[1:0], fail_d, cnt_d}, {2'd1, 1'b1, 5'd0});
    check_val("oor_vec", vec_d, '0);

    // lambda0 == 0
    run(40'h0000000200, 32'h0, 0, '0, '0, 30);
    check_val("inv_summary", {n_done[1:0], fail_d}, {2'd1, 1'b1});
    check_val("inv_vec", vec_d, '0);

    // restart 5 cycles into a single-error scan with the two-error case
    run(40'h0000000801, 32'h00000055, 5, 40'h0000262701, om2, 35);
    check_val("rst_scan_dones", n_done, 1);
    check_val("rst_scan_done_at", done_at, 17);
    check_val("rst_scan_events", n_ev, 2);
    check_val("rst_scan_summary", {fail_d, cnt_d}, {1'b0, 5'd2});
    check_val("rst_scan_vec", vec_d, vec2);

    // reset asserted mid-scan
    @(negedge clk);
    lamda = 40'h0000000801; omega = 32'h00000055; start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    check_val("midrst_pre_cnt", {busy, err_cnt}, {1'b1, 5'd1});
    rst_n = 1'b0;
    #1;
    check_val("midrst_outs", {busy, err_valid, done, fail, err_cnt, err_pos, err_val}, '0);
    check_val("midrst_vec", err_vec, '0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check_val("midrst_no_done", {dn[7:0], busy}, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
